// File: rtl/detector_conditioner_pkg.sv
// detector_conditioner_pkg
//   Shared constants for the lane detector front-end:
//   - lane index constants (bit position of each lane in the packed ports)
//   - default cycle counts for a 50 MHz system clock
//   - clog2 helper used to size the per-lane counters
package detector_conditioner_pkg;

    localparam int LANE_NS = 0;
    localparam int LANE_SN = 1;
    localparam int LANE_EW = 2;
    localparam int LANE_WE = 3;

    localparam int unsigned DEF_N_LANES         = 4;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;    // 20 ms at 50 MHz
    localparam int unsigned DEF_PEND_W          = 3;
    localparam int unsigned DEF_STUCK_CYCLES    = 500_000_000;  // 10 s at 50 MHz

    // Bits needed to hold values 0 .. v-1 (never less than 1).
    function automatic int clog2(input longint unsigned v);
        longint unsigned x;
        int r;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/detector_conditioner_lane.sv
// detector_lane
//   One detector lane: 2-flop synchronizer, debounce, rising-edge event,
//   saturating pending-event counter and (with STUCK_DETECT_EN) stuck flag.
//   Ports:
//     clk, rst   system clock, asynchronous active-high reset
//     det_raw    raw detector pin (asynchronous)
//     take       one-cycle pulse: consumer drains one pending event
//     det_clean  debounced level
//     car_avail  pending count nonzero
//     pend_cnt   pending event count (saturating)
//     overflow   sticky: an event was lost to saturation
//     stuck      debounced level held high too long (0 without STUCK_DETECT_EN)
module detector_lane
    import detector_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned PEND_W          = DEF_PEND_W
`ifdef STUCK_DETECT_EN
    ,
    parameter int unsigned STUCK_CYCLES    = DEF_STUCK_CYCLES
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              det_raw,
    input  logic              take,
    output logic              det_clean,
    output logic              car_avail,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              overflow,
    output logic              stuck
);

    localparam int DEB_W = clog2(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              stable_q, stable_d;
    logic              stable_dly_q, stable_dly_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              inc;

    // Synchronizer and debounce: the counter only runs while the synchronized
    // input disagrees with the accepted level, so any agreeing sample restarts it.
    always_comb begin
        sync1_d      = det_raw;
        sync2_d      = sync1_q;
        stable_d     = stable_q;
        deb_cnt_d    = '0;
        stable_dly_d = stable_q;
        if (sync2_q != stable_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                stable_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

`ifdef STUCK_DETECT_EN
    localparam int ST_W = clog2(STUCK_CYCLES);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(STUCK_CYCLES - 1);

    logic [ST_W-1:0] st_cnt_q, st_cnt_d;
    logic            stuck_q, stuck_d;

    // Clearing on the falling stable_d makes stuck drop in the same cycle
    // that det_clean falls.
    always_comb begin
        st_cnt_d = st_cnt_q;
        stuck_d  = stuck_q;
        if (!stable_q || !stable_d) begin
            st_cnt_d = '0;
            stuck_d  = 1'b0;
        end else if (st_cnt_q == ST_LAST) begin
            stuck_d  = 1'b1;
        end else begin
            st_cnt_d = st_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_cnt_q <= '0;
            stuck_q  <= 1'b0;
        end else begin
            st_cnt_q <= st_cnt_d;
            stuck_q  <= stuck_d;
        end
    end

    assign inc   = stable_q & ~stable_dly_q & ~stuck_q;
    assign stuck = stuck_q;
`else
    assign inc   = stable_q & ~stable_dly_q;
    assign stuck = 1'b0;
`endif

    // Pending counter: a simultaneous inc and take cancel out, even at the limits.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        case ({inc, take})
            2'b10: begin
                if (pend_q == PEND_MAX) ovf_d  = 1'b1;
                else                    pend_d = pend_q + 1'b1;
            end
            2'b01: begin
                if (pend_q != '0) pend_d = pend_q - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            deb_cnt_q    <= '0;
            pend_q       <= '0;
            ovf_q        <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            deb_cnt_q    <= deb_cnt_d;
            pend_q       <= pend_d;
            ovf_q        <= ovf_d;
        end
    end

    assign det_clean = stable_q;
    assign car_avail = (pend_q != '0);
    assign pend_cnt  = pend_q;
    assign overflow  = ovf_q;

endmodule

// File: rtl/detector_conditioner.sv
// detector_conditioner
//   Front-end for the lane vehicle detectors (bit i = lane i: 0=NS 1=SN 2=EW 3=WE).
//   Optional feature macro: STUCK_DETECT_EN (stuck-lane detection and event
//   suppression; without it stuck is constant 0).
//   Ports:
//     clk, rst   50 MHz system clock, asynchronous active-high reset
//     det_raw    raw detector pins (asynchronous)
//     take       per-lane drain pulse, synchronous to clk
//     det_clean  debounced levels
//     car_avail  per-lane pending count nonzero
//     pend_cnt   pending counts, lane i at [i*PEND_W +: PEND_W]
//     overflow   per-lane sticky saturation loss flag
//     stuck      per-lane stuck flag
module detector_conditioner
    import detector_conditioner_pkg::*;
#(
    parameter int unsigned N_LANES         = DEF_N_LANES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned PEND_W          = DEF_PEND_W
`ifdef STUCK_DETECT_EN
    ,
    parameter int unsigned STUCK_CYCLES    = DEF_STUCK_CYCLES
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_LANES-1:0]        det_raw,
    input  logic [N_LANES-1:0]        take,
    output logic [N_LANES-1:0]        det_clean,
    output logic [N_LANES-1:0]        car_avail,
    output logic [N_LANES*PEND_W-1:0] pend_cnt,
    output logic [N_LANES-1:0]        overflow,
    output logic [N_LANES-1:0]        stuck
);

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        detector_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .PEND_W          (PEND_W)
`ifdef STUCK_DETECT_EN
            ,
            .STUCK_CYCLES    (STUCK_CYCLES)
`endif
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .det_raw   (det_raw[i]),
            .take      (take[i]),
            .det_clean (det_clean[i]),
            .car_avail (car_avail[i]),
            .pend_cnt  (pend_cnt[i*PEND_W +: PEND_W]),
            .overflow  (overflow[i]),
            .stuck     (stuck[i])
        );
    end

endmodule

// File: tb/tb_detector_conditioner.sv
module tb_detector_conditioner;

    localparam int NL  = 4;
    localparam int DEB = 4;
    localparam int PW  = 3;
    localparam int ST  = 20;
    localparam int PMAX = (1 << PW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [NL-1:0]   det_raw;
    logic [NL-1:0]   take;
    logic [NL-1:0]   det_clean;
    logic [NL-1:0]   car_avail;
    logic [NL*PW-1:0] pend_cnt;
    logic [NL-1:0]   overflow;
    logic [NL-1:0]   stuck;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    detector_conditioner #(
        .N_LANES         (NL),
        .DEBOUNCE_CYCLES (DEB),
        .PEND_W          (PW)
`ifdef STUCK_DETECT_EN
        ,
        .STUCK_CYCLES    (ST)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .det_raw   (det_raw),
        .take      (take),
        .det_clean (det_clean),
        .car_avail (car_avail),
        .pend_cnt  (pend_cnt),
        .overflow  (overflow),
        .stuck     (stuck)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lane_pend(input int l);
        return 32'(pend_cnt[l*PW +: PW]);
    endfunction

    // ---------------- behavioural model ----------------
    // m_hist[l][k]: raw pin value sampled k+1 edges ago. The synchronized
    // value seen at this edge is the raw pin from two edges ago (index 1).
    // The debounced level flips once the last DEB synchronized samples all
    // disagree with it.
    bit m_hist   [NL][DEB+1];
    bit m_stable [NL];
    bit m_rose   [NL];
    int m_pend   [NL];
    bit m_ovf    [NL];
    int m_run    [NL];
    bit m_stuck  [NL];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < NL; l++) begin
                for (int k = 0; k <= DEB; k++) m_hist[l][k] = 1'b0;
                m_stable[l] = 0; m_rose[l] = 0; m_pend[l] = 0;
                m_ovf[l] = 0; m_run[l] = 0; m_stuck[l] = 0;
            end
        end else begin
            for (int l = 0; l < NL; l++) begin
                bit all_diff, old_s, new_s, ev;
                all_diff = 1'b1;
                for (int k = 1; k <= DEB; k++)
                    if (m_hist[l][k] == m_stable[l]) all_diff = 1'b0;
                old_s = m_stable[l];
                new_s = all_diff ? !old_s : old_s;
                ev    = m_rose[l] && !m_stuck[l];
                if (ev && !take[l]) begin
                    if (m_pend[l] == PMAX) m_ovf[l] = 1'b1;
                    else m_pend[l]++;
                end else if (!ev && take[l]) begin
                    if (m_pend[l] > 0) m_pend[l]--;
                end
                m_rose[l] = new_s && !old_s;
`ifdef STUCK_DETECT_EN
                if (!new_s) begin
                    m_run[l] = 0; m_stuck[l] = 0;
                end else if (!old_s) begin
                    m_run[l] = 0;
                end else begin
                    if (m_run[l] < ST) m_run[l]++;
                    if (m_run[l] >= ST) m_stuck[l] = 1'b1;
                end
`else
                m_stuck[l] = 1'b0;
`endif
                m_stable[l] = new_s;
                for (int k = DEB; k >= 1; k--) m_hist[l][k] = m_hist[l][k-1];
                m_hist[l][0] = det_raw[l];
            end
        end
    end

    // Compare DUT with model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [NL-1:0] e_clean, e_avail, e_ovf, e_stuck;
            logic [NL*PW-1:0] e_pend;
            for (int l = 0; l < NL; l++) begin
                e_clean[l] = m_stable[l];
                e_avail[l] = (m_pend[l] != 0);
                e_ovf[l]   = m_ovf[l];
                e_stuck[l] = m_stuck[l];
                e_pend[l*PW +: PW] = PW'(m_pend[l]);
            end
            check("mdl_det_clean", 32'(det_clean), 32'(e_clean));
            check("mdl_car_avail", 32'(car_avail), 32'(e_avail));
            check("mdl_pend_cnt",  32'(pend_cnt),  32'(e_pend));
            check("mdl_overflow",  32'(overflow),  32'(e_ovf));
            check("mdl_stuck",     32'(stuck),     32'(e_stuck));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic press(input int l, input int hold);
        @(negedge clk) det_raw[l] = 1'b1;
        repeat (hold) @(negedge clk);
        det_raw[l] = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic take_pulse(input int l);
        @(negedge clk) take[l] = 1'b1;
        @(negedge clk) take[l] = 1'b0;
    endtask

    // Press whose event cycle coincides with a take pulse on the same lane.
    task automatic press_with_take(input int l);
        @(negedge clk) det_raw[l] = 1'b1;
        repeat (6) @(negedge clk);
        take[l] = 1'b1;
        @(negedge clk) take[l] = 1'b0;
        repeat (2) @(negedge clk);
        det_raw[l] = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; det_raw = '0; take = '0;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_clean", 32'(det_clean), 0);
        check("reset_pend",  32'(pend_cnt),  0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);

        // Clean press on lane 0: det_clean after exactly 6 edges.
        @(negedge clk) det_raw[0] = 1'b1;
        repeat (5) @(posedge clk);
        #1 check("press_lat5", 32'(det_clean), 32'h0);
        @(posedge clk);
        #1 check("press_lat6", 32'(det_clean), 32'h1);
        @(posedge clk);
        #1 check("press_pend0", lane_pend(0), 1);
        check("press_avail", 32'(car_avail), 32'h1);
        repeat (3) @(negedge clk);
        det_raw[0] = 1'b0;
        repeat (10) @(negedge clk);
        check("press_fall_no_event", lane_pend(0), 1);
        take_pulse(0);
        #1 check("press_drained", lane_pend(0), 0);

        // Glitch rejection on lane 1, then a just-long-enough pulse.
        press(1, 3);
        check("glitch_clean", 32'(det_clean[1]), 0);
        check("glitch_pend",  lane_pend(1), 0);
        press(1, 4);
        check("pulse4_pend",  lane_pend(1), 1);
        take_pulse(1);

        // Saturation on lane 2.
        repeat (9) press(2, 8);
        check("sat_pend", lane_pend(2), 7);
        check("sat_ovf",  32'(overflow[2]), 1);
        repeat (7) take_pulse(2);
        #1 check("sat_drained", lane_pend(2), 0);
        check("sat_avail",    32'(car_avail[2]), 0);
        check("sat_ovf_kept", 32'(overflow[2]), 1);
        take_pulse(2);
        #1 check("sat_underflow", lane_pend(2), 0);

        // Simultaneous inc and take on lane 3, at max and at zero.
        repeat (7) press(3, 8);
        check("sim_pend7", lane_pend(3), 7);
        press_with_take(3);
        check("sim_max_pend", lane_pend(3), 7);
        check("sim_max_ovf",  32'(overflow[3]), 0);
        repeat (7) take_pulse(3);
        press_with_take(3);
        check("sim_zero_pend", lane_pend(3), 0);

        // Asynchronous reset with lane 0 at 2 and lane 1 mid-debounce.
        press(0, 8);
        press(0, 8);
        check("arst_pre_pend0", lane_pend(0), 2);
        @(negedge clk) det_raw[1] = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_clean", 32'(det_clean), 0);
        check("arst_pend",  32'(pend_cnt),  0);
        check("arst_avail", 32'(car_avail), 0);
        check("arst_ovf",   32'(overflow),  0);
        check("arst_stuck", 32'(stuck),     0);
        @(negedge clk) rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("arst_rel_lat5", 32'(det_clean[1]), 0);
        @(posedge clk);
        #1 check("arst_rel_lat6", 32'(det_clean[1]), 1);
        @(posedge clk);
        #1 check("arst_rel_pend1", lane_pend(1), 1);
        @(negedge clk) det_raw[1] = 1'b0;
        repeat (10) @(negedge clk);
        take_pulse(1);

        // Long hold on lane 0: stuck behaviour.
        @(negedge clk) det_raw[0] = 1'b1;
        repeat (6 + ST - 1) @(posedge clk);
        #1 check("stuck_before", 32'(stuck[0]), 0);
        @(posedge clk);
`ifdef STUCK_DETECT_EN
        #1 check("stuck_set", 32'(stuck[0]), 1);
`else
        #1 check("stuck_off", 32'(stuck[0]), 0);
`endif
        repeat (14) @(negedge clk);
        det_raw[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("stuck_hold_clean", 32'(det_clean[0]), 1);
        @(posedge clk);
        #1 check("stuck_clr_clean", 32'(det_clean[0]), 0);
        check("stuck_clr", 32'(stuck[0]), 0);
        repeat (6) @(negedge clk);
        take_pulse(0);
        #1 check("stuck_drained", lane_pend(0), 0);
        press(0, 8);
        check("stuck_after_press", lane_pend(0), 1);

        // Randomized traffic on all lanes, checked by the model every cycle.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int l = 0; l < NL; l++) begin
                if ($urandom_range(0, 5) == 0) det_raw[l] = !det_raw[l];
                take[l] = ($urandom_range(0, 3) == 0);
            end
        end
        @(negedge clk) take = '0; det_raw = '0;
        repeat (12) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
